gpio_bank_ctrl: RTL and testbench
=================================

// Module: gpio_bank_ctrl
// PURPOSE
//  Parametrised memory-mapped GPIO bank: decodes a word-offset address into NUM_IN input
//  ports, NUM_OUT output registers, and an interrupt status/mask pair. Registered write
//  strobes, a registered read mux with a valid flag, 2-flop input synchronisers and
//  per-port change-detect interrupts. Sits on the processor data bus beside data memory.
// PARAMETERS
//  DW       32  data width of every port/register
//  NUM_IN    2  input ports, 1..8
//  NUM_OUT   2  output ports, 1..8
//  AW        4  word-offset address width; 2^AW >= NUM_IN+NUM_OUT+2
// PORTS
//  clk       in   1            rising-edge clock; the block's only clock
//  rst       in   1            reset, asynchronous, active-low (0 = reset)
//  a         in   AW           word offset within the GPIO window
//  we        in   1            write request, sampled at clk rise
//  re        in   1            read request, sampled at clk rise
//  wd        in   DW           write data
//  rd        out  DW           read data, registered
//  rd_valid  out  1            1-cycle pulse: rd holds the data for the previous-cycle re
//  gpi       in   NUM_IN*DW    asynchronous inputs, port i = gpi[i*DW +: DW]
//  gpo       out  NUM_OUT*DW   output registers, port j = gpo[j*DW +: DW]
//  irq       out  1            registered OR of (status & mask)
//  addr_err  out  1            1-cycle pulse: previous-cycle we/re hit an unmapped offset
// BEHAVIOUR
//  Map: IN(i)=i (RO); OUT(j)=NUM_IN+j (RW); STAT=NUM_IN+NUM_OUT (RO, W1C);
//   MASK=STAT+1 (RW, low NUM_IN bits only, upper bits read 0). Other offsets are unmapped.
//  Reset (rst=0, async): gpo, mask, status, sync flops, rd, rd_valid, irq and addr_err all 0.
//   A reset mid-access drops the access; there is no pulse after release.
//  Write: we=1 at edge k updates the target register at edge k. gpo is visible after edge k.
//   Writes to IN offsets are ignored without error.
//  Read: re=1 at edge k -> rd/rd_valid valid after edge k (1-cycle latency), held until the
//   next re. rd_valid is high for exactly one cycle per accepted read. Unmapped read -> rd=0.
//  we & re in the same cycle to the same offset: the write is applied, and rd returns the
//   pre-write value.
//  Sync: each gpi port goes through s1->s2; s3 is a delayed copy of s2. IN(i) reads s2.
//   status[i] sets when s2!=s3 (any bit). Detection is 3 edges after the input change.
//  W1C: writing STAT with wd[i]=1 clears status[i]. A set event and a clear in the same
//   cycle -> the set wins. Status bits saturate: there is no count and no overflow.
//  irq = |(status & mask), registered, so it follows status/mask with 1 cycle of latency.
//  addr_err: pulses for we or re to an offset >= NUM_IN+NUM_OUT+2.
//   Registers are unchanged on an error.
//  Widths: all registers are DW wide. Upper bits of wd beyond NUM_IN are ignored on STAT/MASK.
// TESTING
//  1 reset: assert rst=0 mid-write -> all outputs 0; after release, no rd_valid or
//    addr_err pulse.
//  2 write OUT(1)=0xDEADBEEF -> gpo[63:32]=DEADBEEF after that edge. Read it back ->
//    rd=DEADBEEF and rd_valid=1 for 1 cycle, 1 edge after re.
//  3 gpi port0 0->0x5 with MASK=0x1 -> status[0]=1 at edge 3 and irq=1 at edge 4.
//    W1C write 0x1 -> irq drops 1 cycle later.
//  4 W1C of status[0] in the same cycle as a new port0 change -> status[0] stays 1.
//  5 we&re same cycle on OUT(0) (old 0x11, new 0x22) -> rd=0x11, then gpo=0x22.
//  6 read/write offset 15 (unmapped, defaults) -> addr_err 1-cycle pulse, rd=0,
//    no register changed.

Source files
------------

// File: rtl/gpio_bank_ctrl.sv
// Memory-mapped GPIO bank: synchronised input ports with change-detect interrupts,
// output registers, a write-1-to-clear status register and an interrupt mask.
module gpio_bank_ctrl #(
  parameter int DW      = 32,
  parameter int NUM_IN  = 2,
  parameter int NUM_OUT = 2,
  parameter int AW      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [AW-1:0]         a,
  input  logic                  we,
  input  logic                  re,
  input  logic [DW-1:0]         wd,
  output logic [DW-1:0]         rd,
  output logic                  rd_valid,
  input  logic [NUM_IN*DW-1:0]  gpi,
  output logic [NUM_OUT*DW-1:0] gpo,
  output logic                  irq,
  output logic                  addr_err
);

  localparam int STAT_OFF = NUM_IN + NUM_OUT;
  localparam int MASK_OFF = STAT_OFF + 1;
  localparam int NUM_MAP  = STAT_OFF + 2;
  localparam int AXW      = AW + 1;

  logic [AXW-1:0]        a_ext_s;
  logic [NUM_IN-1:0]     in_sel_s;
  logic [NUM_OUT-1:0]    out_sel_s;
  logic                  stat_sel_s;
  logic                  mask_sel_s;
  logic                  unmapped_s;
  logic [NUM_IN*DW-1:0]  s1_r;
  logic [NUM_IN*DW-1:0]  s2_r;
  logic [NUM_IN*DW-1:0]  s3_r;
  logic [NUM_OUT*DW-1:0] out_r;
  logic [NUM_IN-1:0]     status_r;
  logic [NUM_IN-1:0]     mask_r;
  logic [NUM_IN-1:0]     chg_s;
  logic [NUM_IN-1:0]     clr_s;
  logic [NUM_IN-1:0]     status_nxt_s;
  logic [DW-1:0]         rdata_s;
  logic [DW-1:0]         rd_r;
  logic                  rd_valid_r;
  logic                  irq_r;
  logic                  addr_err_r;

  // The extra top bit keeps the unmapped compare correct when 2^AW == NUM_MAP.
  assign a_ext_s    = {1'b0, a};
  assign stat_sel_s = (a_ext_s == AXW'(STAT_OFF));
  assign mask_sel_s = (a_ext_s == AXW'(MASK_OFF));
  assign unmapped_s = (a_ext_s >= AXW'(NUM_MAP));

  // Address decode for the input and output port windows
  always_comb begin
    in_sel_s  = '0;
    out_sel_s = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      in_sel_s[i] = (a_ext_s == AXW'(i));
    end
    for (int j = 0; j < NUM_OUT; j++) begin
      out_sel_s[j] = (a_ext_s == AXW'(NUM_IN + j));
    end
  end

  // Change detect and W1C merge; a set in the same cycle as a clear wins
  always_comb begin
    chg_s = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      chg_s[i] = |(s2_r[i*DW +: DW] ^ s3_r[i*DW +: DW]);
    end
    clr_s        = (we && stat_sel_s) ? wd[NUM_IN-1:0] : '0;
    status_nxt_s = (status_r & ~clr_s) | chg_s;
  end

  // Read mux: one-hot AND-OR select, unmapped offsets fall through to zero
  always_comb begin
    rdata_s = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      rdata_s = rdata_s | ({DW{in_sel_s[i]}} & s2_r[i*DW +: DW]);
    end
    for (int j = 0; j < NUM_OUT; j++) begin
      rdata_s = rdata_s | ({DW{out_sel_s[j]}} & out_r[j*DW +: DW]);
    end
    rdata_s = rdata_s | ({DW{stat_sel_s}} & DW'(status_r))
                      | ({DW{mask_sel_s}} & DW'(mask_r));
  end

  // Input synchronisers plus the delayed copy used for change detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_r <= '0;
      s2_r <= '0;
      s3_r <= '0;
    end else begin
      s1_r <= gpi;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  // Writable registers: outputs, mask, status and the interrupt line
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_r    <= '0;
      mask_r   <= '0;
      status_r <= '0;
      irq_r    <= 1'b0;
    end else begin
      for (int j = 0; j < NUM_OUT; j++) begin
        if (we && out_sel_s[j]) begin
          out_r[j*DW +: DW] <= wd;
        end
      end
      if (we && mask_sel_s) begin
        mask_r <= wd[NUM_IN-1:0];
      end
      status_r <= status_nxt_s;
      irq_r    <= |(status_r & mask_r);
    end
  end

  // Registered read response and error pulse; rd holds until the next read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_r       <= '0;
      rd_valid_r <= 1'b0;
      addr_err_r <= 1'b0;
    end else begin
      if (re) begin
        rd_r <= rdata_s;
      end
      rd_valid_r <= re;
      addr_err_r <= (we | re) & unmapped_s;
    end
  end

  assign rd       = rd_r;
  assign rd_valid = rd_valid_r;
  assign gpo      = out_r;
  assign irq      = irq_r;
  assign addr_err = addr_err_r;

endmodule

// File: tb/tb_gpio_bank_ctrl.sv
// Scoreboard bench for gpio_bank_ctrl: directed accesses push expected read data and
// error flags; a monitor pops and compares them as the DUT responds.
module tb_gpio_bank_ctrl;

  localparam int DW      = 32;
  localparam int NUM_IN  = 2;
  localparam int NUM_OUT = 2;
  localparam int AW      = 4;

  localparam logic [AW-1:0] IN0  = 4'd0;
  localparam logic [AW-1:0] IN1  = 4'd1;
  localparam logic [AW-1:0] OUT0 = 4'd2;
  localparam logic [AW-1:0] OUT1 = 4'd3;
  localparam logic [AW-1:0] STAT = 4'd4;
  localparam logic [AW-1:0] MASK = 4'd5;

  logic                  clk;
  logic                  rst;
  logic [AW-1:0]         a;
  logic                  we;
  logic                  re;
  logic [DW-1:0]         wd;
  logic [DW-1:0]         rd;
  logic                  rd_valid;
  logic [NUM_IN*DW-1:0]  gpi;
  logic [NUM_OUT*DW-1:0] gpo;
  logic                  irq;
  logic                  addr_err;

  int vectors = 0;
  int fails   = 0;
  logic [DW-1:0] rd_q[$];
  logic          err_q[$];

  gpio_bank_ctrl #(.DW(DW), .NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .AW(AW)) dut (
    .clk(clk), .rst(rst), .a(a), .we(we), .re(re), .wd(wd), .rd(rd),
    .rd_valid(rd_valid), .gpi(gpi), .gpo(gpo), .irq(irq), .addr_err(addr_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic access(input logic w, input logic r, input logic [AW-1:0] adr,
                        input logic [DW-1:0] d, input logic [DW-1:0] exp_rd,
                        input logic exp_err);
    @(negedge clk);
    we = w;
    re = r;
    a  = adr;
    wd = d;
    if (r) rd_q.push_back(exp_rd);
    if (w | r) err_q.push_back(exp_err);
  endtask

  task automatic idle();
    @(negedge clk);
    we = 1'b0;
    re = 1'b0;
  endtask

  // Monitor: compares every response against the scoreboard queues
  initial begin : monitor
    bit had_req;
    bit had_re;
    forever begin
      @(posedge clk);
      had_req = (we | re) & rst;
      had_re  = re & rst;
      #1;
      chk("rd_valid", 64'(rd_valid), 64'(had_re));
      if (rd_valid) begin
        if (rd_q.size() == 0) begin
          vectors++;
          fails++;
          $display("FAIL rd_unexpected: got rd_valid=1 rd=%h, want no response", rd);
        end else begin
          chk("rd", 64'(rd), 64'(rd_q.pop_front()));
        end
      end
      if (had_req && err_q.size() > 0) begin
        chk("addr_err", 64'(addr_err), 64'(err_q.pop_front()));
      end else begin
        chk("addr_err_idle", 64'(addr_err), 64'(1'b0));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000 ns, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    we  = 1'b0;
    re  = 1'b0;
    a   = '0;
    wd  = '0;
    gpi = '0;
    #2 rst = 1'b0;
    @(negedge clk);
    chk("reset_rd", 64'(rd), 64'h0);
    chk("reset_gpo", 64'(gpo), 64'h0);
    chk("reset_irq", 64'(irq), 64'h0);
    @(negedge clk);
    rst = 1'b1;

    // Reset in the middle of a write drops it and clears every output
    access(1'b1, 1'b0, OUT0, 32'h0000_0011, 32'h0, 1'b0);
    access(1'b0, 1'b1, OUT0, 32'h0, 32'h0000_0011, 1'b0);
    @(negedge clk);
    we = 1'b1;
    re = 1'b0;
    a  = OUT0;
    wd = 32'hAAAA_5555;
    #2 rst = 1'b0;
    #1;
    chk("rst_rd", 64'(rd), 64'h0);
    chk("rst_rd_valid", 64'(rd_valid), 64'h0);
    chk("rst_gpo", 64'(gpo), 64'h0);
    chk("rst_irq", 64'(irq), 64'h0);
    chk("rst_addr_err", 64'(addr_err), 64'h0);
    @(posedge clk);
    #1;
    chk("rst_drop_write", 64'(gpo), 64'h0);
    @(negedge clk);
    we  = 1'b0;
    rst = 1'b1;
    idle();
    idle();
    chk("post_rst_gpo", 64'(gpo), 64'h0);

    // Output register write and read-back
    access(1'b1, 1'b0, OUT1, 32'hDEAD_BEEF, 32'h0, 1'b0);
    idle();
    chk("gpo_out1", 64'(gpo[63:32]), 64'hDEAD_BEEF);
    chk("gpo_out0", 64'(gpo[31:0]), 64'h0);
    access(1'b0, 1'b1, OUT1, 32'h0, 32'hDEAD_BEEF, 1'b0);
    idle();
    idle();
    chk("rd_hold", 64'(rd), 64'hDEAD_BEEF);

    // Change-detect interrupt, masked to port 0 only
    access(1'b1, 1'b0, MASK, 32'hFFFF_FFFD, 32'h0, 1'b0);
    access(1'b0, 1'b1, MASK, 32'h0, 32'h0000_0001, 1'b0);
    idle();
    @(negedge clk);
    gpi[31:0] = 32'h0000_0005;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("irq_pre", 64'(irq), 64'h0);
    @(posedge clk);
    #1;
    chk("irq_set", 64'(irq), 64'h1);
    access(1'b0, 1'b1, STAT, 32'h0, 32'h0000_0001, 1'b0);
    access(1'b0, 1'b1, IN0, 32'h0, 32'h0000_0005, 1'b0);
    access(1'b1, 1'b0, STAT, 32'h0000_0001, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    chk("irq_hold_on_clr", 64'(irq), 64'h1);
    idle();
    @(posedge clk);
    #1;
    chk("irq_clr", 64'(irq), 64'h0);
    access(1'b0, 1'b1, STAT, 32'h0, 32'h0, 1'b0);

    // Clear colliding with a new change: the set wins
    @(negedge clk);
    we = 1'b0;
    re = 1'b0;
    gpi[31:0] = 32'h0000_0006;
    idle();
    idle();
    idle();
    idle();
    @(negedge clk);
    gpi[31:0] = 32'h0000_0007;
    idle();
    access(1'b1, 1'b0, STAT, 32'h0000_0001, 32'h0, 1'b0);
    access(1'b0, 1'b1, STAT, 32'h0, 32'h0000_0001, 1'b0);
    access(1'b1, 1'b0, STAT, 32'hFFFF_FFFE, 32'h0, 1'b0);
    access(1'b0, 1'b1, STAT, 32'h0, 32'h0000_0001, 1'b0);
    access(1'b1, 1'b0, STAT, 32'h0000_0001, 32'h0, 1'b0);
    access(1'b0, 1'b1, STAT, 32'h0, 32'h0, 1'b0);

    // Write and read of the same offset in one cycle returns the old value
    access(1'b1, 1'b0, OUT0, 32'h0000_0011, 32'h0, 1'b0);
    access(1'b1, 1'b1, OUT0, 32'h0000_0022, 32'h0000_0011, 1'b0);
    idle();
    chk("gpo_after_rw", 64'(gpo[31:0]), 64'h22);

    // Unmapped offsets, ignored IN writes, and nothing else disturbed
    access(1'b0, 1'b1, 4'd15, 32'h0, 32'h0, 1'b1);
    access(1'b1, 1'b0, 4'd15, 32'hFFFF_FFFF, 32'h0, 1'b1);
    access(1'b1, 1'b0, IN0, 32'h0000_1234, 32'h0, 1'b0);
    access(1'b0, 1'b1, 4'd6, 32'h0, 32'h0, 1'b1);
    access(1'b0, 1'b1, OUT0, 32'h0, 32'h0000_0022, 1'b0);
    access(1'b0, 1'b1, OUT1, 32'h0, 32'hDEAD_BEEF, 1'b0);
    access(1'b0, 1'b1, MASK, 32'h0, 32'h0000_0001, 1'b0);
    access(1'b0, 1'b1, IN0, 32'h0, 32'h0000_0007, 1'b0);
    access(1'b0, 1'b1, IN1, 32'h0, 32'h0, 1'b0);
    access(1'b0, 1'b1, STAT, 32'h0, 32'h0, 1'b0);
    idle();
    idle();
    chk("gpo_final", 64'(gpo), 64'hDEAD_BEEF_0000_0022);
    chk("rd_q_drained", 64'(rd_q.size()), 64'h0);
    chk("err_q_drained", 64'(err_q.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
